// File: rtl/axis_frame_master.sv
// rtl/axis_frame_master.sv - two-beat buffered AXI4-Stream video frame transmitter
// Optional: define AXIS_FRAME_MASTER_STATS_EN to add stat_beats/stat_stalls counters.
module axis_frame_master #(
    parameter int DATA_WIDTH      = 32,
    parameter int PIXELS_PER_LINE = 640,
    parameter int LINES_PER_FRAME = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  frame_done,
    output logic                  busy
`ifdef AXIS_FRAME_MASTER_STATS_EN
    ,
    output logic [31:0]           stat_beats,
    output logic [31:0]           stat_stalls
`endif
);

    localparam int PW = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1;
    localparam int LW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
    localparam logic [PW-1:0] PIX_MAX  = PW'(PIXELS_PER_LINE - 1);
    localparam logic [LW-1:0] LINE_MAX = LW'(LINES_PER_FRAME - 1);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [1:0]            occ_q;
    logic [PW-1:0]         pix_cnt;
    logic [LW-1:0]         line_cnt;
    logic                  frame_done_q;
    logic                  push;
    logic                  pop;
    logic                  pix_at_max;
    logic                  line_at_max;

    assign m_axis_tvalid = (occ_q != 2'd0);
    assign in_ready      = !rst && (occ_q != 2'd2);
    assign push          = in_valid && in_ready;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign pix_at_max    = (pix_cnt == PIX_MAX);
    assign line_at_max   = (line_cnt == LINE_MAX);

    // Head register feeds the stream directly, so tdata cannot glitch while stalled.
    assign m_axis_tdata  = head_q;
    assign m_axis_tlast  = m_axis_tvalid && pix_at_max;
    assign m_axis_tuser  = m_axis_tvalid && (pix_cnt == '0) && (line_cnt == '0);
    assign frame_done    = frame_done_q;
    assign busy          = m_axis_tvalid || (pix_cnt != '0) || (line_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            occ_q        <= 2'd0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            // Push while full and pop while empty cannot occur, which keeps this shift simple.
            if (pop && occ_q == 2'd2) begin
                head_q <= tail_q;
            end else if (push && (occ_q == 2'd0 || pop)) begin
                head_q <= in_data;
            end
            if (push && !pop && occ_q == 2'd1) begin
                tail_q <= in_data;
            end

            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase

            if (pop) begin
                if (pix_at_max) begin
                    pix_cnt  <= '0;
                    line_cnt <= line_at_max ? '0 : line_cnt + 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end

            frame_done_q <= pop && pix_at_max && line_at_max;
        end
    end

`ifdef AXIS_FRAME_MASTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beats  <= 32'd0;
            stat_stalls <= 32'd0;
        end else begin
            if (pop) begin
                stat_beats <= stat_beats + 32'd1;
            end
            if (m_axis_tvalid && !m_axis_tready) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_frame_master.sv
// tb/tb_axis_frame_master.sv - self-checking bench for axis_frame_master (4 px/line, 2 lines/frame)
module tb_axis_frame_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        frame_done;
    logic        busy;
`ifdef AXIS_FRAME_MASTER_STATS_EN
    logic [31:0] stat_beats;
    logic [31:0] stat_stalls;
`endif

    axis_frame_master #(
        .DATA_WIDTH(32),
        .PIXELS_PER_LINE(4),
        .LINES_PER_FRAME(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .frame_done(frame_done),
        .busy(busy)
`ifdef AXIS_FRAME_MASTER_STATS_EN
        ,
        .stat_beats(stat_beats),
        .stat_stalls(stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
        logic        eof;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
        logic        eof;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    int          checks = 0;
    int          errors = 0;
    int          model_idx = 0;
    int          fd_count = 0;
    int          fd_before;
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_eof = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic        prev_user;
    logic        ok;
    logic        done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] d, input logic last, input logic user,
                             input logic eof, input logic track);
        exp_t e;
        logic acc;
        acc = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                if (track) begin
                    e.data = d; e.last = last; e.user = user; e.eof = eof;
                    sb.push_back(e);
                    model_idx++;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_auto(input logic [31:0] d);
        push_beat(d, (model_idx % 4) == 3, (model_idx % 8) == 0, (model_idx % 8) == 7, 1'b1);
    endtask

    task automatic drain();
        logic empty;
        empty = 1'b0;
        for (int i = 0; i < 500 && !empty; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !m_axis_tvalid) empty = 1'b1;
        end
        if (!empty) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        model_idx = 0;
    endtask

    // Scoreboard monitor: compares every transferred beat and the frame_done pulse timing.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
            prev_eof   = 1'b0;
        end else if (mon_en) begin
            check("frame_done", frame_done, prev_eof);
            if (frame_done) fd_count++;
            if (prev_stall) begin
                check("stall_tvalid", m_axis_tvalid, 1'b1);
                check("stall_tdata", m_axis_tdata, prev_data);
                check("stall_tlast", m_axis_tlast, prev_last);
                check("stall_tuser", m_axis_tuser, prev_user);
            end
            prev_eof = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", m_axis_tdata, 32'd0);
                    if (m_axis_tdata == 32'd0) check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("beat_tdata", m_axis_tdata, e.data);
                    check("beat_tlast", m_axis_tlast, e.last);
                    check("beat_tuser", m_axis_tuser, e.user);
                    prev_eof = e.eof;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            prev_user  = m_axis_tuser;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i].data = i;
            vecs[i].last = (i == 3) || (i == 7);
            vecs[i].user = (i == 0);
            vecs[i].eof  = (i == 7);
        end

        rst = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; m_axis_tready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_in_ready", in_ready, 1'b0);
            check("rst_tvalid", m_axis_tvalid, 1'b0);
            check("rst_tdata", m_axis_tdata, 32'd0);
            check("rst_tlast", m_axis_tlast, 1'b0);
            check("rst_tuser", m_axis_tuser, 1'b0);
            check("rst_frame_done", frame_done, 1'b0);
            check("rst_busy", busy, 1'b0);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Streaming: one full frame at full rate
        m_axis_tready = 1'b1;
        fd_before = fd_count;
        for (int i = 0; i < 8; i++)
            push_beat(vecs[i].data, vecs[i].last, vecs[i].user, vecs[i].eof, 1'b1);
        drain();
        check("stream_fd_count", fd_count - fd_before, 1);

        // Backpressure: third push must wait until the slave is ready
        m_axis_tready = 1'b0;
        push_auto(32'hA5A5A5A5);
        push_auto(32'h12345678);
        fork
            push_auto(32'hDEADBEEF);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 1'b0);
                    check("bp_tdata", m_axis_tdata, 32'hA5A5A5A5);
                    check("bp_tvalid", m_axis_tvalid, 1'b1);
                end
                @(posedge clk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        drain();

        // Random backpressure over three frames
        fd_before = fd_count;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) push_auto($urandom);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_axis_tready = 1'($urandom % 2);
                    @(posedge clk);
                    #1;
                end
                m_axis_tready = 1'b1;
            end
        join
        drain();
        check("rand_fd_count", fd_count - fd_before, 3);

        // Mid-frame reset discards buffered beat and partial frame
        reset_cycles(2);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 6; i++) push_auto(32'h100 + i);
        drain();
        m_axis_tready = 1'b0;
        push_beat(32'h0000_0BAD, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        fd_before = fd_count;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_frame_done", frame_done, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        model_idx = 0;
        push_beat(32'hFACEFADE, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("mid_rst_first_tdata", m_axis_tdata, 32'hFACEFADE);
        check("mid_rst_first_tuser", m_axis_tuser, 1'b1);
        check("mid_rst_first_tlast", m_axis_tlast, 1'b0);
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        drain();
        check("mid_rst_fd_count", fd_count - fd_before, 0);

`ifdef AXIS_FRAME_MASTER_STATS_EN
        reset_cycles(2);
        @(negedge clk);
        check("stat_beats_rst", stat_beats, 32'd0);
        check("stat_stalls_rst", stat_stalls, 32'd0);
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        fork
            for (int i = 0; i < 8; i++) push_auto(32'h200 + i);
            begin
                ok = 1'b0;
                for (int i = 0; i < 100 && !ok; i++) begin
                    @(negedge clk);
                    if (m_axis_tvalid) ok = 1'b1;
                end
                if (!ok) check("stat_tvalid_timeout", 32'd0, 32'd1);
                repeat (3) @(posedge clk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        drain();
        check("stat_beats", stat_beats, 32'd8);
        check("stat_stalls", stat_stalls, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
